// File: rtl/mips_cpu_pkg.sv
// mips_cpu_pkg: state, instruction-class and mux-select encodings shared by the MIPS control path
package mips_cpu_pkg;
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;
   typedef enum logic [3:0] {
      C_RTYPE, C_ITYPE, C_LOAD, C_STORE, C_BRANCH, C_JUMP, C_JAL, C_JR, C_INVALID
   } cls_t;
   localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                          OP_BNE = 6'h05, OP_ADDIU = 6'h09, OP_SLTI = 6'h0a, OP_SLTIU = 6'h0b,
                          OP_ANDI = 6'h0c, OP_ORI = 6'h0d, OP_XORI = 6'h0e, OP_LUI = 6'h0f,
                          OP_LW = 6'h23, OP_SW = 6'h2b;
   localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_JR = 6'h08,
                          FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_AND = 6'h24, FN_OR = 6'h25,
                          FN_XOR = 6'h26, FN_NOR = 6'h27, FN_SLT = 6'h2a, FN_SLTU = 6'h2b;
   localparam logic       PC_SRC_SEQ = 1'b0, PC_SRC_TGT = 1'b1;
   localparam logic [1:0] TGT_BRANCH = 2'd0, TGT_JUMP = 2'd1, TGT_RS = 2'd2;
   localparam logic [1:0] DST_RT = 2'd0, DST_RD = 2'd1, DST_R31 = 2'd2;
   localparam logic [1:0] WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC8 = 2'd2;
endpackage

// File: rtl/mips_cpu_ctrl_fsm_if.sv
// mips_cpu_ctrl_fsm_if: instruction fields, memory handshake and datapath strobes of the control sequencer
interface mips_cpu_ctrl_fsm_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       sig_branch;
   logic       mem_waitrequest;
   logic       pc_zero;
   logic       active;
   logic       mem_read;
   logic       mem_write;
   logic       addr_sel;
   logic       ir_we;
   logic       pc_we;
   logic       pc_src;
   logic       tgt_we;
   logic [1:0] tgt_sel;
   logic       reg_we;
   logic [1:0] reg_dst;
   logic [1:0] wb_sel;
   logic       alu_b_sel;
   logic [2:0] state_o;
   modport master (
      input  opcode, funct, sig_branch, mem_waitrequest, pc_zero,
      output active, mem_read, mem_write, addr_sel, ir_we, pc_we, pc_src, tgt_we, tgt_sel,
             reg_we, reg_dst, wb_sel, alu_b_sel, state_o
   );
   modport slave (
      output opcode, funct, sig_branch, mem_waitrequest, pc_zero,
      input  active, mem_read, mem_write, addr_sel, ir_we, pc_we, pc_src, tgt_we, tgt_sel,
             reg_we, reg_dst, wb_sel, alu_b_sel, state_o
   );
endinterface

// File: rtl/mips_cpu_ctrl_decode.sv
// mips_cpu_ctrl_decode: combinational opcode/funct classifier; anything unrecognised is C_INVALID (run as NOP)
module mips_cpu_ctrl_decode
   import mips_cpu_pkg::*;
(
   input  logic [5:0] i_opcode,
   input  logic [5:0] i_funct,
   output cls_t       o_cls
);
   always_comb begin
      o_cls = C_INVALID;
      case (i_opcode)
         OP_RTYPE:
            case (i_funct)
               FN_SLL, FN_SRL, FN_SRA, FN_ADDU, FN_SUBU, FN_AND, FN_OR,
               FN_XOR, FN_NOR, FN_SLT, FN_SLTU: o_cls = C_RTYPE;
               FN_JR:   o_cls = C_JR;
               default: o_cls = C_INVALID;
            endcase
         OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: o_cls = C_ITYPE;
         OP_LW:         o_cls = C_LOAD;
         OP_SW:         o_cls = C_STORE;
         OP_BEQ, OP_BNE: o_cls = C_BRANCH;
         OP_J:          o_cls = C_JUMP;
         OP_JAL:        o_cls = C_JAL;
         default:       o_cls = C_INVALID;
      endcase
   end
endmodule

// File: rtl/mips_cpu_ctrl_fsm.sv
// mips_cpu_ctrl_fsm: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with wait states and halt at PC 0.
// Define MIPS_CPU_DELAY_SLOT_EN to redirect the PC one instruction late (branch delay slot).
module mips_cpu_ctrl_fsm
   import mips_cpu_pkg::*;
(
   input logic                  clk,
   input logic                  rst_n,
   mips_cpu_ctrl_fsm_if.master  bus
);
   state_t r_state;
   logic   r_taken;
   cls_t   w_cls;
   logic   w_taken, w_tgt_ok, w_pc_src;
   logic   w_f, w_e, w_m, w_w;
   mips_cpu_ctrl_decode u_decode (
      .i_opcode (bus.opcode),
      .i_funct  (bus.funct),
      .o_cls    (w_cls)
   );
   assign w_taken = (w_cls == C_BRANCH && bus.sig_branch) || w_cls inside {C_JUMP, C_JAL, C_JR};
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_FETCH;
         r_taken <= 1'b0;
      end else begin
         case (r_state)
            S_FETCH:  r_state <= bus.pc_zero ? S_HALT : (bus.mem_waitrequest ? S_FETCH : S_DECODE);
            S_DECODE: r_state <= S_EXEC;
            S_EXEC: begin
               r_state <= (w_cls inside {C_LOAD, C_STORE}) ? S_MEM : S_WB;
               r_taken <= w_taken;
            end
            S_MEM:    r_state <= bus.mem_waitrequest ? S_MEM : S_WB;
            S_WB:     r_state <= S_FETCH;
            default:  r_state <= S_HALT;
         endcase
      end
   end
`ifdef MIPS_CPU_DELAY_SLOT_EN
   logic r_pending;
   // a redirect recorded at WB is applied at the following instruction's WB
   always_ff @(posedge clk) begin
      if (!rst_n) r_pending <= 1'b0;
      else if (r_state == S_WB) r_pending <= !r_pending && r_taken;
   end
   assign w_tgt_ok = !r_pending;
   assign w_pc_src = r_pending;
`else
   assign w_tgt_ok = 1'b1;
   assign w_pc_src = r_taken;
`endif
   assign w_f = rst_n && r_state == S_FETCH && !bus.pc_zero;
   assign w_e = rst_n && r_state == S_EXEC;
   assign w_m = rst_n && r_state == S_MEM;
   assign w_w = rst_n && r_state == S_WB;
   assign bus.active    = rst_n && r_state != S_HALT;
   assign bus.mem_read  = w_f || (w_m && w_cls == C_LOAD);
   assign bus.mem_write = w_m && w_cls == C_STORE;
   assign bus.addr_sel  = w_m;
   assign bus.ir_we     = w_f && !bus.mem_waitrequest;
   assign bus.pc_we     = w_w;
   assign bus.pc_src    = (w_w && w_pc_src) ? PC_SRC_TGT : PC_SRC_SEQ;
   assign bus.tgt_we    = w_e && w_taken && w_tgt_ok;
   assign bus.tgt_sel   = !w_e ? TGT_BRANCH : w_cls == C_JR ? TGT_RS :
                          (w_cls inside {C_JUMP, C_JAL}) ? TGT_JUMP : TGT_BRANCH;
   assign bus.alu_b_sel = w_e && w_cls inside {C_ITYPE, C_LOAD, C_STORE};
   assign bus.reg_we    = w_w && w_cls inside {C_RTYPE, C_ITYPE, C_LOAD, C_JAL};
   assign bus.reg_dst   = !w_w ? DST_RT : w_cls == C_RTYPE ? DST_RD : w_cls == C_JAL ? DST_R31 : DST_RT;
   assign bus.wb_sel    = !w_w ? WB_ALU : w_cls == C_LOAD ? WB_MEM : w_cls == C_JAL ? WB_PC8 : WB_ALU;
   assign bus.state_o   = rst_n ? r_state : S_FETCH;
endmodule
